// File: rtl/memory_stage_if.sv
// Data-memory bus between the Y86-64 memory stage and data memory.
// Request/grant/read-valid handshake:
//   mem_req    stage -> mem   access request, held until mem_gnt
//   mem_we     stage -> mem   1 = write, 0 = read (valid with mem_req)
//   mem_addr   stage -> mem   byte address
//   mem_wdata  stage -> mem   write data
//   mem_gnt    mem -> stage   request accepted this cycle
//   mem_rvalid mem -> stage   read data valid
//   mem_rdata  mem -> stage   read data
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 pipeline memory stage.
// Accepts one instruction at a time from E/M, classifies it as read
// (mrmovq, popq, ret), write (rmmovq, pushq, call) or no-op, performs the
// data-memory access over the memory_stage_if bus and presents a registered
// result to writeback as a one-cycle out_valid pulse.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  E/M handshake; in_ready is high only in IDLE
//   in_*                 icode, valE, valA, valP, cond, dstE, dstM, stat
//   mem                  data-memory bus (master side)
//   out_valid, out_*     registered result; fields hold until next completion
module memory_stage #(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [63:0] in_valE,
    input  logic [63:0] in_valA,
    input  logic [63:0] in_valP,
    input  logic        in_cond,
    input  logic [3:0]  in_dstE,
    input  logic [3:0]  in_dstM,
    input  logic [1:0]  in_stat,
    memory_stage_if.master mem,
    output logic        out_valid,
    output logic [3:0]  out_icode,
    output logic [63:0] out_valE,
    output logic [63:0] out_valM,
    output logic        out_cond,
    output logic [3:0]  out_dstE,
    output logic [3:0]  out_dstM,
    output logic [1:0]  out_stat
);

    // Highest start address of a legal 8-byte access; the unsigned 64-bit
    // compare against it also rejects addresses that would wrap.
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
    // Counter value seen during the TIMEOUT-th cycle of waiting.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0]  STAT_AOK = 2'b00;
    localparam logic [1:0]  STAT_ADR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [3:0]  icode_r;
    logic [63:0] vale_r;
    logic        cond_r;
    logic [3:0]  dste_r;
    logic [3:0]  dstm_r;

    logic        is_read_s;
    logic        is_write_s;
    logic [63:0] addr_s;
    logic [63:0] wdata_s;
    logic        bypass_s;
    logic [1:0]  bypass_stat_s;
    logic        done_s;
    logic [63:0] done_valm_s;
    logic [1:0]  done_stat_s;

    assign in_ready = (state_r == IDLE);

    // Decode the incoming instruction: access kind, address, write data, bypass.
    always_comb begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
        addr_s     = in_valE;
        wdata_s    = in_valA;
        case (in_icode)
            4'h4, 4'hA: is_write_s = 1'b1;
            4'h8: begin
                is_write_s = 1'b1;
                wdata_s    = in_valP;
            end
            4'h5: is_read_s = 1'b1;
            4'h9, 4'hB: begin
                is_read_s = 1'b1;
                addr_s    = in_valA;
            end
            default: begin
                is_read_s  = 1'b0;
                is_write_s = 1'b0;
            end
        endcase

        // A non-AOK status wins over address checking and passes through.
        if (in_stat != STAT_AOK) begin
            bypass_s      = 1'b1;
            bypass_stat_s = in_stat;
        end else if (!(is_read_s || is_write_s)) begin
            bypass_s      = 1'b1;
            bypass_stat_s = STAT_AOK;
        end else if (addr_s > ADDR_MAX) begin
            bypass_s      = 1'b1;
            bypass_stat_s = STAT_ADR;
        end else begin
            bypass_s      = 1'b0;
            bypass_stat_s = STAT_AOK;
        end
    end

    // Completion of an outstanding access: grant/read data win over timeout.
    always_comb begin
        done_s      = 1'b0;
        done_valm_s = 64'd0;
        done_stat_s = STAT_AOK;
        case (state_r)
            REQ: begin
                if (mem.mem_gnt) begin
                    if (mem.mem_we) begin
                        done_s = 1'b1;
                    end else if (mem.mem_rvalid) begin
                        done_s      = 1'b1;
                        done_valm_s = mem.mem_rdata;
                    end else begin
                        done_s = 1'b0;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    done_s      = 1'b1;
                    done_stat_s = STAT_ADR;
                end else begin
                    done_s = 1'b0;
                end
            end
            WAIT_RD: begin
                if (mem.mem_rvalid) begin
                    done_s      = 1'b1;
                    done_valm_s = mem.mem_rdata;
                end else if (cnt_r == CNT_LAST) begin
                    done_s      = 1'b1;
                    done_stat_s = STAT_ADR;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: done_s = 1'b0;
        endcase
    end

    // Stage FSM with registered bus request and writeback result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= 8'd0;
            icode_r       <= 4'd0;
            vale_r        <= 64'd0;
            cond_r        <= 1'b0;
            dste_r        <= 4'd0;
            dstm_r        <= 4'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 64'd0;
            mem.mem_wdata <= 64'd0;
            out_valid     <= 1'b0;
            out_icode     <= 4'd0;
            out_valE      <= 64'd0;
            out_valM      <= 64'd0;
            out_cond      <= 1'b0;
            out_dstE      <= 4'd0;
            out_dstM      <= 4'd0;
            out_stat      <= STAT_AOK;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        icode_r <= in_icode;
                        vale_r  <= in_valE;
                        cond_r  <= in_cond;
                        dste_r  <= in_dstE;
                        dstm_r  <= in_dstM;
                        if (bypass_s) begin
                            out_valid <= 1'b1;
                            out_icode <= in_icode;
                            out_valE  <= in_valE;
                            out_valM  <= 64'd0;
                            out_cond  <= in_cond;
                            out_dstE  <= in_dstE;
                            out_dstM  <= in_dstM;
                            out_stat  <= bypass_stat_s;
                        end else begin
                            state_r       <= REQ;
                            cnt_r         <= 8'd0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_write_s;
                            mem.mem_addr  <= addr_s;
                            mem.mem_wdata <= wdata_s;
                        end
                    end
                end
                REQ, WAIT_RD: begin
                    if (done_s) begin
                        state_r     <= IDLE;
                        mem.mem_req <= 1'b0;
                        out_valid   <= 1'b1;
                        out_icode   <= icode_r;
                        out_valE    <= vale_r;
                        out_valM    <= done_valm_s;
                        out_cond    <= cond_r;
                        out_dstE    <= dste_r;
                        out_dstM    <= dstm_r;
                        out_stat    <= done_stat_s;
                    end else if ((state_r == REQ) && mem.mem_gnt) begin
                        // Read granted without data: wait with a fresh budget.
                        state_r     <= WAIT_RD;
                        mem.mem_req <= 1'b0;
                        cnt_r       <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    localparam int MEM_BYTES = 8192;
    localparam int TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [63:0] in_valE, in_valA, in_valP;
    logic        in_cond;
    logic [3:0]  in_dstE, in_dstM;
    logic [1:0]  in_stat;
    logic        out_valid;
    logic [3:0]  out_icode;
    logic [63:0] out_valE, out_valM;
    logic        out_cond;
    logic [3:0]  out_dstE, out_dstM;
    logic [1:0]  out_stat;

    memory_stage_if mbus();

    memory_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_valE(in_valE), .in_valA(in_valA), .in_valP(in_valP),
        .in_cond(in_cond), .in_dstE(in_dstE), .in_dstM(in_dstM), .in_stat(in_stat),
        .mem(mbus),
        .out_valid(out_valid), .out_icode(out_icode), .out_valE(out_valE),
        .out_valM(out_valM), .out_cond(out_cond), .out_dstE(out_dstE),
        .out_dstM(out_dstM), .out_stat(out_stat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_done = -100;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: 0 = no-op, 1 = read, 2 = write.
    function automatic int kind(input logic [3:0] ic);
        if (ic == 4'h5 || ic == 4'h9 || ic == 4'hB) return 1;
        if (ic == 4'h4 || ic == 4'h8 || ic == 4'hA) return 2;
        return 0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Issue one instruction (called at a negedge) and follow it to completion.
    // gd: cycles without grant before the grant cycle; rd: cycles after the
    // grant cycle until rvalid (0 = same cycle). Large values never respond.
    task automatic run_op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                          input logic [63:0] vp, input logic c, input logic [3:0] de,
                          input logic [3:0] dm, input logic [1:0] st,
                          input int gd, input int rd, input logic [63:0] rdata);
        int          kd;
        logic [63:0] ea, wd, evm;
        bit          byp, seen, busy_ok;
        logic [1:0]  est;
        int          lat, k;
        kd  = kind(ic);
        ea  = (ic == 4'h9 || ic == 4'hB) ? va : ve;
        wd  = (ic == 4'h8) ? vp : va;
        byp = 1'b0;
        est = st;
        evm = 64'd0;
        if (st != 2'b00 || kd == 0) byp = 1'b1;
        else if (ea > 64'(MEM_BYTES - 8)) begin byp = 1'b1; est = 2'b10; end
        if (byp) lat = 1;
        else if (gd >= TIMEOUT) begin lat = TIMEOUT + 1; est = 2'b10; end
        else if (kd == 2) lat = gd + 2;
        else if (rd > TIMEOUT) begin lat = gd + 2 + TIMEOUT; est = 2'b10; end
        else begin lat = gd + rd + 2; evm = rdata; end

        in_icode = ic; in_valE = ve; in_valA = va; in_valP = vp;
        in_cond = c; in_dstE = de; in_dstM = dm; in_stat = st; in_valid = 1'b1;
        check("ready_at_accept", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble inputs so that only latched values can produce the result.
        in_icode = 4'($urandom); in_valE = rnd64(); in_valA = rnd64(); in_valP = rnd64();
        in_cond = 1'($urandom); in_dstE = 4'($urandom); in_dstM = 4'($urandom);
        in_stat = 2'($urandom);
        k = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && k <= 60) begin
            if (k == 1) begin
                if (byp) begin
                    check("no_req_bypass", 128'(mbus.mem_req), 128'(1'b0));
                end else begin
                    check("req_fields", {61'd0, mbus.mem_req, out_valid, mbus.mem_we, mbus.mem_addr},
                          {61'd0, 1'b1, 1'b0, (kd == 2), ea});
                    if (kd == 2) check("wdata", 128'(mbus.mem_wdata), 128'(wd));
                end
            end
            if (out_valid) begin
                seen = 1'b1;
                last_done = cyc;
                check("latency", 128'(k), 128'(lat));
                check("out_fields", {115'd0, out_icode, out_cond, out_dstE, out_dstM},
                      {115'd0, ic, c, de, dm});
                check("out_valE", 128'(out_valE), 128'(ve));
                check("out_valM", 128'(out_valM), 128'(evm));
                check("out_stat", 128'(out_stat), 128'(est));
                check("req_low_at_done", 128'(mbus.mem_req), 128'(1'b0));
            end else begin
                if (!byp && in_ready !== 1'b0) busy_ok = 1'b0;
                mbus.mem_gnt = (!byp && k == 1 + gd);
                if (kd == 1) begin
                    mbus.mem_rvalid = (!byp && k == 1 + gd + rd);
                    mbus.mem_rdata  = mbus.mem_rvalid ? rdata : rnd64();
                end else begin
                    // Stray read-valid while a write is pending must be ignored.
                    mbus.mem_rvalid = 1'($urandom);
                    mbus.mem_rdata  = rnd64();
                end
                @(posedge clk);
                @(negedge clk);
                k++;
            end
        end
        mbus.mem_gnt = 1'b0;
        mbus.mem_rvalid = 1'b0;
        check("completed", 128'(seen), 128'(1'b1));
        if (!byp) check("busy_not_ready", 128'(busy_ok), 128'(1'b1));
    endtask

    initial begin
        int t1;
        rst_n = 1'b0;
        in_valid = 1'b0; in_icode = 4'd0; in_valE = 64'd0; in_valA = 64'd0; in_valP = 64'd0;
        in_cond = 1'b0; in_dstE = 4'd0; in_dstM = 4'd0; in_stat = 2'd0;
        mbus.mem_gnt = 1'b0; mbus.mem_rvalid = 1'b0; mbus.mem_rdata = 64'd0;
        repeat (2) @(negedge clk);
        check("rst_bus", {mbus.mem_req, mbus.mem_we, mbus.mem_addr, mbus.mem_wdata[61:0]}, 128'd0);
        check("rst_wdata", 128'(mbus.mem_wdata), 128'd0);
        check("rst_out", {43'd0, out_valid, out_icode, out_valE, out_cond, out_dstE, out_dstM, out_stat},
              128'd0);
        check("rst_valM", 128'(out_valM), 128'd0);
        check("rst_ready", 128'(in_ready), 128'(1'b1));
        rst_n = 1'b1;
        @(negedge clk);

        // rmmovq, immediate grant
        run_op(4'h4, 64'h100, 64'hDEAD, 64'h0, 1'b1, 4'hF, 4'hF, 2'b00, 0, 0, 64'd0);
        // call: data is valP
        run_op(4'h8, 64'h1F8, 64'h0, 64'h42, 1'b1, 4'h4, 4'hF, 2'b00, 0, 0, 64'd0);
        // popq: grant after 3 waits, rvalid 2 cycles later
        run_op(4'hB, 64'h208, 64'h200, 64'h0, 1'b1, 4'h4, 4'h3, 2'b00, 3, 2, 64'h1234);
        // mrmovq: grant and rvalid together, then gnt then rvalid next
        run_op(4'h5, 64'h40, 64'h0, 64'h0, 1'b0, 4'hF, 4'h7, 2'b00, 0, 0, 64'hCAFE);
        run_op(4'h5, 64'h1FF8, 64'h0, 64'h0, 1'b0, 4'hF, 4'h7, 2'b00, 0, 1, 64'hBEEF);
        // out-of-range: last byte beyond memory, and 64-bit wrap
        run_op(4'h5, 64'h1FF9, 64'h0, 64'h0, 1'b1, 4'hF, 4'h2, 2'b00, 0, 0, 64'd0);
        run_op(4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 4'h4, 4'hF, 2'b00, 0, 0, 64'd0);
        // timeouts: read never returns data, write never granted
        run_op(4'h5, 64'h80, 64'h0, 64'h0, 1'b1, 4'hF, 4'h1, 2'b00, 0, 99, 64'd0);
        run_op(4'hA, 64'h88, 64'h77, 64'h0, 1'b1, 4'h4, 4'hF, 2'b00, 99, 0, 64'd0);

        // back-to-back bypass: OPq, irmovq, HLT
        run_op(4'h6, 64'h11, 64'h0, 64'h0, 1'b1, 4'h1, 4'hF, 2'b00, 0, 0, 64'd0);
        t1 = last_done;
        run_op(4'h3, 64'h22, 64'h0, 64'h0, 1'b1, 4'h2, 4'hF, 2'b00, 0, 0, 64'd0);
        check("b2b_gap1", 128'(last_done - t1), 128'd1);
        t1 = last_done;
        run_op(4'h0, 64'h33, 64'h0, 64'h0, 1'b1, 4'hF, 4'hF, 2'b01, 0, 0, 64'd0);
        check("b2b_gap2", 128'(last_done - t1), 128'd1);
        @(negedge clk);
        check("pulse_single", 128'(out_valid), 128'(1'b0));
        check("stat_hold", 128'(out_stat), 128'(2'b01));

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a[2];
            int gd, rd;
            for (int j = 0; j < 2; j++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 7) a[j] = 64'($urandom_range(0, MEM_BYTES - 8));
                else if (r < 9) a[j] = rnd64();
                else a[j] = 64'(MEM_BYTES - 8 + $urandom_range(1, 7));
            end
            gd = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3);
            rd = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3);
            run_op(4'($urandom), a[0], a[1], rnd64(), 1'($urandom), 4'($urandom), 4'($urandom),
                   ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00, gd, rd, rnd64());
        end

        // reset in the middle of a pending request
        in_icode = 4'h5; in_valE = 64'h80; in_stat = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("req_before_reset", 128'(mbus.mem_req), 128'(1'b1));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_req", {126'd0, mbus.mem_req, out_valid}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 128'(in_ready), 128'(1'b1));
        check("no_req_after_reset", 128'(mbus.mem_req), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory stage of the Y86-64 pipeline, the consumer of the execute stage's valE/cond results. It accepts one instruction at a time from the E/M boundary and classifies it as read, write or no-op. It drives a request/grant/read-valid handshake to data memory and stalls upstream while an access is outstanding. It then presents a registered result (valE, valM, dst, stat) to writeback.

Parameters:
MEM_BYTES, 8192, size of data memory in bytes; a legal 8-byte access needs addr <= MEM_BYTES-8
TIMEOUT, 15, maximum cycles spent in REQ or WAIT_RD before the access is aborted

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  E/M holds an instruction
in_ready  output  1  stage can accept; combinational, equals (state==IDLE)
in_icode  input  4  Y86 icode
in_valE  input  64  execute result / effective address
in_valA  input  64  register operand (store data; pop/ret address)
in_valP  input  64  next PC (call store data)
in_cond  input  1  execute condition flag
in_dstE, in_dstM  input  4 each  destination register IDs (0xF = none)
in_stat  input  2  00 AOK, 01 HLT, 10 ADR, 11 INS
mem_req  output  1  access request, held until mem_gnt
mem_we  output  1  1 = write, 0 = read; valid with mem_req
mem_addr  output  64  byte address
mem_wdata  output  64  write data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  64  read data
out_valid  output  1  one-cycle pulse; result fields valid
out_icode  output  4  registered icode
out_valE, out_valM  output  64 each  registered valE; loaded data (0 for non-reads)
out_cond  output  1  registered in_cond
out_dstE, out_dstM  output  4 each  registered destinations
out_stat  output  2  final status

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, all out_* =0, out_stat=00. Reset mid-access abandons it; mem_req drops immediately; the instruction is lost.
- Classification: reads are mrmovq(5), popq(B), ret(9). Writes are rmmovq(4), pushq(A), call(8). All other icodes are no-ops.
- Address: in_valE for 4,5,8,A; in_valA for 9,B. Write data: in_valA for 4,A; in_valP for 8.
- Accept: fire when in_valid && in_ready. Latch all in_* fields.
- Bypass cases, no memory request, return to/stay in IDLE, out_valid next cycle:
  - op is a no-op.
  - in_stat != AOK; the status passes through unchanged.
  - address > MEM_BYTES-8, including wrap of 64-bit unsigned compare; out_stat=ADR.
- FSM states:
  - IDLE: in_ready=1. A memory op with AOK status and a legal address goes to REQ, with mem_req asserted from the next cycle.
  - REQ: mem_req=1 and the address, we and data are held stable. On mem_gnt, a write goes to IDLE with out_valid next cycle. On mem_gnt, a read goes to WAIT_RD, or completes directly if mem_rvalid is also high that cycle.
  - WAIT_RD: on mem_rvalid, capture mem_rdata into out_valM, out_valid next cycle, go to IDLE.
- Timeout: a counter is cleared on entering REQ and on gnt, and increments each cycle in REQ/WAIT_RD. Reaching TIMEOUT drops mem_req, sets out_stat=ADR and out_valM=0, pulses out_valid, and goes to IDLE.
- Latency from the accept cycle N:
  - no-op/bypass: out_valid at N+1.
  - write with immediate gnt: N+2.
  - read with gnt at N+1 and rvalid at N+2: N+3.
- Throughput: back-to-back no-ops sustain 1 per cycle. A new accept can coincide with the out_valid of the previous instruction.
- Stray mem_rvalid in IDLE or REQ-write is ignored. mem_gnt outside REQ is ignored.
- out_valid is high exactly one cycle per accepted instruction. The out_* fields hold their values until the next completion.

Test Plan:
- Reset: rst_n low mid-REQ -> mem_req=0 immediately, out_valid=0, in_ready=1 after release.
- Write: rmmovq (icode 4), valE=0x100, valA=0xDEAD; gnt on first REQ cycle -> mem_we=1, addr=0x100, wdata=0xDEAD; out_valid at N+2, stat=AOK.
- Call: call (icode 8), valE=0x1F8, valP=0x42 -> wdata=0x42, addr=0x1F8.
- Read: popq (icode B), valA=0x200; gnt after 3 wait cycles; rvalid 2 cycles later with rdata=0x1234 -> addr=0x200, we=0, out_valM=0x1234, in_ready low throughout.
- Address out of range: mrmovq with valE=0x1FF9 (MEM_BYTES=8192) -> no mem_req, out_stat=ADR at N+1. Separately, a read with no rvalid for 15 cycles -> out_stat=ADR, mem_req dropped.
- Bypass: OPq, irmovq and in_stat=HLT back-to-back, 3 cycles -> three consecutive out_valid pulses, no mem_req, out_valE matches inputs, HLT passed through.
